// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and widths for the pipeline stall/flush controller.
// Optional performance counters are enabled with PIPE_PERF_EN.
package pipe_hazard_ctrl_pkg;

    localparam int unsigned REG_IDX_W = 3;
    localparam int unsigned DATA_W    = 16;
    localparam int unsigned CNT_W     = 16;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        MWAIT  = 2'd1,
        DRAIN  = 2'd2,
        HALTED = 2'd3
    } state_e;

    // Per-cycle pipeline-register control bundle
    typedef struct packed {
        logic pc_stall;
        logic ifid_stall;
        logic ifid_flush;
        logic idex_stall;
        logic idex_flush;
        logic exmem_stall;
        logic exmem_flush;
        logic memwb_flush;
        logic pc_redirect;
        logic halted;
    } ctl_t;

endpackage

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// Combinational load-use comparator; also instanced by the forwarding unit.
module hazard_detect
    import pipe_hazard_ctrl_pkg::*;
(
    input  logic                 ex_memread,
    input  logic [REG_IDX_W-1:0] ex_rd,
    input  logic [REG_IDX_W-1:0] id_rs,
    input  logic [REG_IDX_W-1:0] id_rt,
    input  logic                 id_rs_used,
    input  logic                 id_rt_used,
    output logic                 lu_hazard
);

    always_comb begin
        lu_hazard = ex_memread &&
                    ((id_rs_used && (id_rs == ex_rd)) ||
                     (id_rt_used && (id_rt == ex_rd)));
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush/redirect/halt controller for the five-stage pipeline.
// Define PIPE_PERF_EN to add the saturating stall_cnt/flush_cnt counters.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic [REG_IDX_W-1:0] id_rs,
    input  logic [REG_IDX_W-1:0] id_rt,
    input  logic                 id_rs_used,
    input  logic                 id_rt_used,
    input  logic                 ex_memread,
    input  logic [REG_IDX_W-1:0] ex_rd,
    input  logic                 mem_branch_taken,
    input  logic                 mem_jump,
    input  logic                 mem_jalr,
    input  logic                 mem_halt,
    input  logic                 imem_busy,
    input  logic                 dmem_busy,
    output logic                 pc_stall,
    output logic                 ifid_stall,
    output logic                 ifid_flush,
    output logic                 idex_stall,
    output logic                 idex_flush,
    output logic                 exmem_stall,
    output logic                 exmem_flush,
    output logic                 memwb_flush,
    output logic                 pc_redirect,
    output logic                 halted
`ifdef PIPE_PERF_EN
    ,
    output logic [CNT_W-1:0]     stall_cnt,
    output logic [CNT_W-1:0]     flush_cnt
`endif
);

    state_e state_q;
    state_e state_d;
    ctl_t   ctl;
    logic   lu_hazard;
    logic   redirect;

    hazard_detect u_hazard_detect (
        .ex_memread (ex_memread),
        .ex_rd      (ex_rd),
        .id_rs      (id_rs),
        .id_rt      (id_rt),
        .id_rs_used (id_rs_used),
        .id_rt_used (id_rt_used),
        .lu_hazard  (lu_hazard)
    );

    assign redirect = mem_branch_taken || mem_jump || mem_jalr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // MWAIT keeps EX/MEM frozen, so a pending halt/redirect is seen again on release
    always_comb begin
        ctl     = '0;
        state_d = state_q;
        case (state_q)
            RUN, MWAIT: begin
                if (dmem_busy) begin
                    ctl.pc_stall    = 1'b1;
                    ctl.ifid_stall  = 1'b1;
                    ctl.idex_stall  = 1'b1;
                    ctl.exmem_stall = 1'b1;
                    ctl.memwb_flush = 1'b1;
                    state_d         = MWAIT;
                end else if (mem_halt) begin
                    ctl.pc_stall    = 1'b1;
                    ctl.ifid_flush  = 1'b1;
                    ctl.idex_flush  = 1'b1;
                    ctl.exmem_flush = 1'b1;
                    state_d         = DRAIN;
                end else if (redirect) begin
                    ctl.pc_redirect = 1'b1;
                    ctl.ifid_flush  = 1'b1;
                    ctl.idex_flush  = 1'b1;
                    ctl.exmem_flush = 1'b1;
                    state_d         = RUN;
                end else begin
                    if (lu_hazard) begin
                        ctl.pc_stall   = 1'b1;
                        ctl.ifid_stall = 1'b1;
                        ctl.idex_flush = 1'b1;
                    end
                    if (imem_busy) begin
                        ctl.pc_stall   = 1'b1;
                        ctl.ifid_flush = !lu_hazard;
                    end
                    state_d = RUN;
                end
            end
            DRAIN: begin
                ctl.pc_stall    = 1'b1;
                ctl.ifid_flush  = 1'b1;
                ctl.idex_flush  = 1'b1;
                ctl.exmem_flush = 1'b1;
                state_d         = HALTED;
            end
            HALTED: begin
                ctl.pc_stall    = 1'b1;
                ctl.ifid_stall  = 1'b1;
                ctl.idex_stall  = 1'b1;
                ctl.exmem_stall = 1'b1;
                ctl.halted      = 1'b1;
            end
            default: begin
                state_d = RUN;
            end
        endcase
        if (!rst) begin
            ctl = '0;
        end
    end

    assign pc_stall    = ctl.pc_stall;
    assign ifid_stall  = ctl.ifid_stall;
    assign ifid_flush  = ctl.ifid_flush;
    assign idex_stall  = ctl.idex_stall;
    assign idex_flush  = ctl.idex_flush;
    assign exmem_stall = ctl.exmem_stall;
    assign exmem_flush = ctl.exmem_flush;
    assign memwb_flush = ctl.memwb_flush;
    assign pc_redirect = ctl.pc_redirect;
    assign halted      = ctl.halted;

`ifdef PIPE_PERF_EN
    // Saturating event counters, frozen once the core has halted
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else if (state_q != HALTED) begin
            if (ctl.pc_stall && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            if (ctl.pc_redirect && (flush_cnt != '1)) begin
                flush_cnt <= flush_cnt + CNT_W'(1);
            end
        end
    end
`endif

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Central stall/flush controller for the 16-bit five-stage pipeline. It watches the ID, ID/EX and EX/MEM stage contents and the instruction/data memory busy signals. It drives the stall and flush inputs of every pipeline register and the PC, and produces the fetch redirect. Branches, jumps and JALR resolve in MEM. The block also sequences processor halt and holds the pipeline frozen across multi-cycle data-memory accesses.

## Interface
- No parameters; the register-index width (3) and data width (16) are package constants.
- clk  in  1  pipeline clock
- rst  in  1  reset; one clock, reset is asynchronous and active-low
- id_rs, id_rt  in  3 each  source registers of the instruction in ID
- id_rs_used, id_rt_used  in  1 each  source actually read
- ex_memread  in  1  ID/EX holds a load
- ex_rd  in  3  load destination
- mem_branch_taken, mem_jump, mem_jalr  in  1 each  EX/MEM control-transfer flags (taken condition already resolved)
- mem_halt  in  1  EX/MEM holds HALT
- imem_busy, dmem_busy  in  1 each  memory not ready this cycle
- pc_stall  out  1  hold PC
- ifid_stall, ifid_flush  out  1 each  IF/ID control
- idex_stall, idex_flush  out  1 each  ID/EX control
- exmem_stall, exmem_flush  out  1 each  EX/MEM control
- memwb_flush  out  1  insert bubble into MEM/WB
- pc_redirect  out  1  PC takes the MEM-stage target this cycle
- halted  out  1  core stopped

## Operation
- States: RUN, MWAIT, DRAIN, HALTED. Reset state is RUN.
- Outputs are combinational from the state and the current inputs. Only the state (plus counters) is registered.
- Priority in RUN, highest first:
  - dmem_busy: all stalls=1, memwb_flush=1, no other flush; next state MWAIT.
  - mem_halt: pc_stall=1; ifid/idex/exmem_flush=1 (younger instructions squashed); next state DRAIN.
  - Redirect (mem_branch_taken|mem_jump|mem_jalr): pc_redirect=1; ifid/idex/exmem_flush=1; stay RUN.
  - Load-use (ex_memread and ex_rd matches a used id_rs/id_rt): pc_stall=1, ifid_stall=1, idex_flush=1.
  - imem_busy: pc_stall=1, ifid_flush=1.
- Load-use and imem_busy may both fire. Their outputs are OR-combined, except that ifid_stall overrides ifid_flush.
- MWAIT: same outputs as the dmem_busy row while dmem_busy=1. When dmem_busy=0, evaluate the RUN priorities in the same cycle and return to RUN.
  - A redirect or halt that is pending in EX/MEM during the wait is held frozen, so it is applied on the release cycle.
- DRAIN: exactly one cycle, with the HALT instruction in WB. pc_stall=1; ifid/idex/exmem_flush=1. Next state HALTED.
- HALTED: halted=1 and every stall=1 until rst. The block ignores all inputs.
- Reset (async, mid-operation included): state goes to RUN, counters clear, and all outputs are 0 while rst=0.

## Timing
- Zero-cycle decision latency: outputs respond in the same cycle as their inputs.
- Redirect costs 3 bubbles (IF, ID, EX squashed).
- Load-use inserts exactly 1 bubble.
- halted rises 2 clocks after the first cycle mem_halt is seen un-frozen.
- dmem_busy held for N cycles freezes the pipeline for exactly N cycles.

## Configuration
- PIPE_PERF_EN defined adds two outputs and two internal counters:
  - stall_cnt (16 bits) counts cycles where pc_stall=1 and state≠HALTED.
  - flush_cnt (16 bits) counts cycles where pc_redirect=1.
  - Both counters saturate at 16'hFFFF, clear on reset, and freeze in HALTED.
- PIPE_PERF_EN undefined: the counters and both ports are absent. Control behaviour is identical either way.

## Structure
- Shared package: state enum (RUN, MWAIT, DRAIN, HALTED), REG_IDX_W=3, DATA_W=16, and the counter width.
- One sub-module, hazard_detect: a purely combinational load-use comparator (ex_memread, ex_rd, id_rs/rt, used flags → lu_hazard). It is reused by the forwarding unit.
- The FSM and the priority encoder stay in the top module.

## Test plan
- Load-use: ex_memread=1, ex_rd=3, id_rs=3, id_rs_used=1 → one cycle of pc_stall=1, ifid_stall=1, idex_flush=1; the following instruction proceeds.
- Taken branch: mem_branch_taken=1 for 1 cycle → pc_redirect=1 and ifid/idex/exmem_flush=1 in that cycle only; state stays RUN.
- dmem_busy high for 4 cycles, together with mem_jump=1 → 4 cycles with all stalls=1 and pc_redirect=0. Release cycle → pc_redirect=1.
- Halt: mem_halt=1 → DRAIN next cycle, halted=1 on the 2nd edge. Afterwards, mem_jump=1 has no effect.
- Async reset asserted mid-MWAIT → all outputs 0 immediately; RUN after release. With PIPE_PERF_EN, counters read 0.
- PIPE_PERF_EN: hold imem_busy for 70000 cycles → stall_cnt=16'hFFFF (saturated, no wrap).
